exe_stage_p: RTL

- Parametrised execute stage for the 16-bit ISA core; sits between decode and fetch.
- Reads operands from an internal register file and executes ALU, branch, call and return instructions.
- Writes back results, updates NZP condition codes and returns the resolved next IP to fetch.
- Adds a valid/ready handshake, a return-address stack (RAS) and sticky error flags.

---
 rtl/exe_pkg.sv | 29 ++
 rtl/exe_if.sv | 35 +++
 rtl/exe_regfile.sv | 29 ++
 rtl/exe_stage_p.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: instruction type codes, ALU ops
// and the link-register index.
package exe_pkg;

   localparam logic [4:0] T_ALU_RR = 5'b00110;
   localparam logic [4:0] T_ALU_RI = 5'b00111;
   localparam logic [4:0] T_ALU_R  = 5'b00100;
   localparam logic [4:0] T_LDI    = 5'b00101;
   localparam logic [4:0] T_BR     = 5'b01001;
   localparam logic [4:0] T_CALL   = 5'b10001;
   localparam logic [4:0] T_RET    = 5'b00000;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } alu_op_e;

   // CALL always links into the highest-numbered register.
   function automatic int link_idx(int reg_aw);
      return (1 << reg_aw) - 1;
   endfunction

endpackage

// File: rtl/exe_if.sv
// Decode-side instruction handshake plus fetch-side result handshake of the
// execute stage; master is the environment, slave is the stage.
interface exe_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int TYPE_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [TYPE_W-1:0] instr_type;
   logic [2:0]        alu_op;
   logic [REG_AW-1:0] sr1;
   logic [REG_AW-1:0] sr2;
   logic [REG_AW-1:0] dr;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] ip;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] next_ip;
   logic              redirect;
   logic              illegal;
   logic [2:0]        nzp;
   logic              ras_ovf;
   logic              ras_unf;

   modport master (
      output in_valid, instr_type, alu_op, sr1, sr2, dr, imm, ip, out_ready,
      input  in_ready, out_valid, next_ip, redirect, illegal, nzp, ras_ovf, ras_unf
   );

   modport slave (
      input  in_valid, instr_type, alu_op, sr1, sr2, dr, imm, ip, out_ready,
      output in_ready, out_valid, next_ip, redirect, illegal, nzp, ras_ovf, ras_unf
   );
endinterface

// File: rtl/exe_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// cleared by synchronous active-low reset.
module exe_regfile #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [DATA_W-1:0] wd
);
   logic [DATA_W-1:0] regs [2**REG_AW];

   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end
endmodule

// File: rtl/exe_stage_p.sv
// Execute stage: ALU/branch/call/return with register file, NZP codes,
// circular return-address stack and a one-deep valid/ready output register.
module exe_stage_p
   import exe_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int REG_AW    = 3,
   parameter int RAS_DEPTH = 4,
   parameter int TYPE_W    = 5
) (
   input logic   clk,
   input logic   rst_n,
   exe_if.slave  bus
);
   localparam logic [REG_AW-1:0] LINK = REG_AW'(link_idx(REG_AW));
   localparam int SH_W  = $clog2(DATA_W);
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   function automatic logic [DATA_W-1:0] alu(alu_op_e op, logic [DATA_W-1:0] a,
                                             logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOT:  r = ~a;
         OP_SHL:  r = a << b[SH_W-1:0];
         default: r = a >> b[SH_W-1:0];
      endcase
      return r;
   endfunction

   function automatic logic [2:0] nzp_of(logic [DATA_W-1:0] v);
      return {v[DATA_W-1], v == '0, !v[DATA_W-1] && (v != '0)};
   endfunction

   logic                     accept;
   logic [DATA_W-1:0]        rd1, rd2, alu_res, operand_b;
   logic signed [DATA_W-1:0] ip_inc_s, imm_s, tgt_s;
   logic [REG_AW-1:0]        ra2;
   logic                     is_ret, is_rr;

   logic [DATA_W-1:0]        nxt_ip, wd;
   logic                     nxt_redirect, nxt_illegal, we, nzp_we, push, pop, unf_set;
   logic [REG_AW-1:0]        wa;

   logic                     vld_p1, redirect_p1, illegal_p1;
   logic [DATA_W-1:0]        next_ip_p1;
   logic [2:0]               nzp_q;
   logic [DATA_W-1:0]        ras [RAS_DEPTH];
   logic [PTR_W-1:0]         sp, sp_inc, sp_dec;
   logic [CNT_W-1:0]         cnt;
   logic                     ovf_q, unf_q;

   assign accept      = bus.in_valid && bus.in_ready;
   assign bus.in_ready = !vld_p1 || bus.out_ready;

   assign is_ret    = (bus.instr_type == TYPE_W'(T_RET));
   assign is_rr     = (bus.instr_type == TYPE_W'(T_ALU_RR));
   // The second read port doubles as the link-register read for an empty-RAS return.
   assign ra2       = is_ret ? LINK : bus.sr2;
   assign operand_b = is_rr ? rd2 : bus.imm;
   assign alu_res   = alu(alu_op_e'(bus.alu_op), rd1, operand_b);

   assign ip_inc_s = signed'(bus.ip + DATA_W'(1));
   assign imm_s    = signed'(bus.imm);
   assign tgt_s    = ip_inc_s + imm_s;

   assign sp_inc = (sp == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp + PTR_W'(1);
   assign sp_dec = (sp == '0) ? PTR_W'(RAS_DEPTH - 1) : sp - PTR_W'(1);

   exe_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
      .clk(clk), .rst_n(rst_n),
      .ra1(bus.sr1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .we(we && accept), .wa(wa), .wd(wd)
   );

   // p0: decode and execute of the offered instruction
   always_comb begin
      nxt_ip       = ip_inc_s;
      nxt_redirect = 1'b0;
      nxt_illegal  = 1'b0;
      we           = 1'b0;
      wa           = bus.dr;
      wd           = alu_res;
      nzp_we       = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      unf_set      = 1'b0;
      case (bus.instr_type)
         TYPE_W'(T_ALU_RR), TYPE_W'(T_ALU_RI), TYPE_W'(T_ALU_R): begin
            we     = 1'b1;
            nzp_we = 1'b1;
         end
         TYPE_W'(T_LDI): begin
            we     = 1'b1;
            nzp_we = 1'b1;
            wd     = bus.imm;
         end
         TYPE_W'(T_BR): begin
            if ((bus.dr[2:0] & nzp_q) != 3'b000) begin
               nxt_ip       = tgt_s;
               nxt_redirect = 1'b1;
            end
         end
         TYPE_W'(T_CALL): begin
            we           = 1'b1;
            wa           = LINK;
            wd           = ip_inc_s;
            push         = 1'b1;
            nxt_ip       = tgt_s;
            nxt_redirect = 1'b1;
         end
         TYPE_W'(T_RET): begin
            nxt_redirect = 1'b1;
            if (cnt != '0) begin
               pop    = 1'b1;
               nxt_ip = ras[sp_dec];
            end else begin
               unf_set = 1'b1;
               nxt_ip  = rd2;
            end
         end
         default: nxt_illegal = 1'b1;
      endcase
   end

   // p1: result register and architectural state updated on the accept edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         next_ip_p1  <= '0;
         redirect_p1 <= 1'b0;
         illegal_p1  <= 1'b0;
         nzp_q       <= 3'b010;
         sp          <= '0;
         cnt         <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else if (accept) begin
         vld_p1      <= 1'b1;
         next_ip_p1  <= nxt_ip;
         redirect_p1 <= nxt_redirect;
         illegal_p1  <= nxt_illegal;
         if (nzp_we) nzp_q <= nzp_of(wd);
         if (unf_set) unf_q <= 1'b1;
         if (push) begin
            sp <= sp_inc;
            if (cnt == CNT_W'(RAS_DEPTH)) ovf_q <= 1'b1;
            else cnt <= cnt + CNT_W'(1);
         end
         if (pop) begin
            sp  <= sp_dec;
            cnt <= cnt - CNT_W'(1);
         end
      end else if (bus.out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   // Stack contents need no reset: the occupancy count decides what is live.
   always_ff @(posedge clk) begin
      if (accept && push) ras[sp] <= ip_inc_s;
   end

   assign bus.out_valid = vld_p1;
   assign bus.next_ip   = next_ip_p1;
   assign bus.redirect  = redirect_p1;
   assign bus.illegal   = illegal_p1;
   assign bus.nzp       = nzp_q;
   assign bus.ras_ovf   = ovf_q;
   assign bus.ras_unf   = unf_q;
endmodule
